// File: rtl/jtframe_cenmon_pkg.sv
// Shared definitions for the clock-enable monitor: FSM encoding and default parameters.
package jtframe_cenmon_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAcq    = 2'd1,
      StLocked = 2'd2,
      StErr    = 2'd3
   } cenmon_state_e;

   localparam int unsigned DefPw    = 8;
   localparam int unsigned DefExp   = 4;
   localparam int unsigned DefTol   = 0;
   localparam int unsigned DefLockN = 4;

endpackage

// File: rtl/jtframe_cenmon_cnt.sv
// Saturating counter of clk cycles since the last clock-enable pulse.
// cnt reads 1 on the cycle after a cen, so on a cen cycle it equals the period.
module jtframe_cenmon_cnt
   import jtframe_cenmon_pkg::*;
#(
   parameter int unsigned PW  = DefPw,
   parameter int unsigned LIM = DefExp + DefTol
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   output logic [PW-1:0] cnt,
   output logic          at_lim,
   output logic          at_max
);

   assign at_lim = (cnt == PW'(LIM));
   assign at_max = &cnt;

   // Restart on every enable, otherwise count up and stick at all ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cen) begin
         cnt <= PW'(1);
      end else if (!at_max) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/jtframe_cen_monitor.sv
// Clock-enable monitor: measures the spacing of cen pulses, reports lock and early/late errors.
// Optional macro JTFRAME_CENMON_MINMAX_EN adds pmin/pmax period extremes.
module jtframe_cen_monitor
   import jtframe_cenmon_pkg::*;
#(
   parameter int unsigned PW     = DefPw,
   parameter int unsigned EXP    = DefExp,
   parameter int unsigned TOL    = DefTol,
   parameter int unsigned LOCK_N = DefLockN
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          clr,
   output logic          locked,
   output logic [PW-1:0] period,
   output logic          err_early,
   output logic          err_late,
   output logic          err_sticky
`ifdef JTFRAME_CENMON_MINMAX_EN
   ,
   output logic [PW-1:0] pmin,
   output logic [PW-1:0] pmax
`endif
);

   // The late check must fire before the counter saturates
   if (EXP + TOL >= (2**PW) - 1) begin : g_bad_params
      $error("jtframe_cen_monitor: EXP+TOL must be below 2^PW-1");
   end

   localparam int          LO = int'(EXP) - int'(TOL);
   localparam int          HI = int'(EXP) + int'(TOL);
   localparam int unsigned GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

   cenmon_state_e state_q;
   logic [GW-1:0] good;
   logic [PW-1:0] cnt;
   logic          at_lim, at_max;
   logic          is_short, is_good;
   logic          early_hit, late_hit;
   int            cnt_val;

   jtframe_cenmon_cnt #(
      .PW  (PW),
      .LIM (EXP + TOL)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .cen    (cen),
      .cnt    (cnt),
      .at_lim (at_lim),
      .at_max (at_max)
   );

   assign cnt_val  = int'(cnt);
   assign is_short = (cnt_val < LO);
   assign is_good  = !is_short && (cnt_val <= HI);

   // Error conditions seen this cycle; they also take priority over clr on the sticky flag
   always_comb begin
      early_hit = 1'b0;
      late_hit  = 1'b0;
      if (cen && is_short && (state_q == StAcq || state_q == StLocked)) early_hit = 1'b1;
      if (!cen && at_lim && (state_q == StLocked)) late_hit = 1'b1;
   end

   // Lock FSM with registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         good       <= '0;
         locked     <= 1'b0;
         period     <= '0;
         err_early  <= 1'b0;
         err_late   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         err_early <= early_hit;
         err_late  <= late_hit;
         if (early_hit || late_hit) begin
            err_sticky <= 1'b1;
         end else if (clr) begin
            err_sticky <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               // first pulse only arms the measurement, its spacing is meaningless
               if (cen) begin
                  state_q <= StAcq;
                  good    <= '0;
               end
            end
            StAcq: begin
               if (cen) begin
                  period <= cnt;
                  if (is_good) begin
                     if (good == GW'(LOCK_N - 1)) begin
                        state_q <= StLocked;
                        locked  <= 1'b1;
                        good    <= '0;
                     end else begin
                        good <= good + 1'b1;
                     end
                  end else begin
                     good <= '0;
                  end
               end else if (at_max) begin
                  state_q <= StIdle;
               end
            end
            StLocked: begin
               if (cen) begin
                  period <= cnt;
                  if (is_short) begin
                     state_q <= StErr;
                     locked  <= 1'b0;
                  end
               end else if (at_lim) begin
                  state_q <= StErr;
                  locked  <= 1'b0;
               end
            end
            StErr: begin
               if (cen) begin
                  period  <= cnt;
                  good    <= '0;
                  state_q <= StAcq;
               end else if (at_max) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef JTFRAME_CENMON_MINMAX_EN
   // Extremes of the measured period since the last clr or reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pmin <= '1;
         pmax <= '0;
      end else if (clr) begin
         pmin <= '1;
         pmax <= '0;
      end else if (cen && state_q != StIdle) begin
         if (cnt < pmin) pmin <= cnt;
         if (cnt > pmax) pmax <= cnt;
      end
   end
`else
   // No period extreme tracking in this build
`endif

endmodule

// File: tb/tb_jtframe_cen_monitor.sv
// Self-checking bench for jtframe_cen_monitor: directed scenarios followed by random
// pulse spacing, all compared each cycle against a timestamp-based reference model.
module tb_jtframe_cen_monitor;

   localparam int unsigned PW     = 8;
   localparam int unsigned EXP    = 4;
   localparam int unsigned TOL    = 0;
   localparam int unsigned LOCK_N = 4;
   localparam int          CMAX   = 255;

   localparam int M_IDLE   = 0;
   localparam int M_ACQ    = 1;
   localparam int M_LOCKED = 2;
   localparam int M_ERR    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cen = 1'b0;
   logic          clr = 1'b0;
   logic          locked;
   logic [PW-1:0] period;
   logic          err_early;
   logic          err_late;
   logic          err_sticky;
`ifdef JTFRAME_CENMON_MINMAX_EN
   logic [PW-1:0] pmin;
   logic [PW-1:0] pmax;
`endif

   jtframe_cen_monitor #(
      .PW     (PW),
      .EXP    (EXP),
      .TOL    (TOL),
      .LOCK_N (LOCK_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .clr        (clr),
      .locked     (locked),
      .period     (period),
      .err_early  (err_early),
      .err_late   (err_late),
      .err_sticky (err_sticky)
`ifdef JTFRAME_CENMON_MINMAX_EN
      ,
      .pmin       (pmin),
      .pmax       (pmax)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: cycle index and timestamp of the last pulse instead of a counter
   int cyc;
   int m_ref;
   int m_mode;
   int m_run;
   int m_period;
   bit m_locked, m_early, m_late, m_sticky;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc      = 0;
      m_ref    = 0;
      m_mode   = M_IDLE;
      m_run    = 0;
      m_period = 0;
      m_locked = 0;
      m_early  = 0;
      m_late   = 0;
      m_sticky = 0;
   endtask

   // Apply one cycle of inputs to the model; results are what the DUT shows after the edge
   task automatic model_step(input bit c, input bit k);
      int per;
      bit short_p, good_p;
      per = cyc - m_ref;
      if (per > CMAX) per = CMAX;
      short_p = (per < int'(EXP) - int'(TOL));
      good_p  = !short_p && (per <= int'(EXP + TOL));
      m_early = 0;
      m_late  = 0;
      case (m_mode)
         M_IDLE: if (c) begin
            m_mode = M_ACQ;
            m_run  = 0;
         end
         M_ACQ: begin
            if (c) begin
               m_period = per;
               if (good_p) begin
                  m_run++;
                  if (m_run == int'(LOCK_N)) begin
                     m_mode   = M_LOCKED;
                     m_locked = 1;
                  end
               end else begin
                  m_run   = 0;
                  m_early = short_p;
               end
            end else if (per == CMAX) begin
               m_mode = M_IDLE;
            end
         end
         M_LOCKED: begin
            if (c) begin
               m_period = per;
               if (short_p) begin
                  m_early  = 1;
                  m_mode   = M_ERR;
                  m_locked = 0;
               end
            end else if (per == int'(EXP + TOL)) begin
               m_late   = 1;
               m_mode   = M_ERR;
               m_locked = 0;
            end
         end
         default: begin
            if (c) begin
               m_period = per;
               m_run    = 0;
               m_mode   = M_ACQ;
            end else if (per == CMAX) begin
               m_mode = M_IDLE;
            end
         end
      endcase
      if (m_early || m_late) m_sticky = 1;
      else if (k)            m_sticky = 0;
      if (c) m_ref = cyc;
   endtask

   task automatic compare_all(input string phase);
      check({phase, ".locked"},     32'(locked),     32'(m_locked));
      check({phase, ".period"},     32'(period),     32'(m_period));
      check({phase, ".err_early"},  32'(err_early),  32'(m_early));
      check({phase, ".err_late"},   32'(err_late),   32'(m_late));
      check({phase, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
   endtask

   task automatic step(input bit c, input bit k, input string phase);
      cen = c;
      clr = k;
      model_step(c, k);
      @(posedge clk);
      #1;
      cyc++;
      compare_all(phase);
   endtask

   // n-1 quiet cycles, then a pulse: pulse spacing n
   task automatic pulse_after(input int n, input string phase);
      for (int i = 0; i < n - 1; i++) step(1'b0, 1'b0, phase);
      step(1'b1, 1'b0, phase);
   endtask

   initial begin
      model_reset();
      #12;
      check("reset.locked",     32'(locked),     0);
      check("reset.period",     32'(period),     0);
      check("reset.err_early",  32'(err_early),  0);
      check("reset.err_late",   32'(err_late),   0);
      check("reset.err_sticky", 32'(err_sticky), 0);
      rst = 1'b0;

      // Lock after the 5th pulse at spacing 4
      for (int i = 0; i < 4; i++) pulse_after(4, "lock");
      check("lock.not_yet", 32'(locked), 0);
      pulse_after(4, "lock");
      check("lock.locked", 32'(locked), 1);
      check("lock.period", 32'(period), 4);
      check("lock.sticky", 32'(err_sticky), 0);

      // Missing pulse: late error after the 4th quiet cycle
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "miss");
      check("miss.err_late", 32'(err_late), 1);
      check("miss.locked",   32'(locked),   0);
      check("miss.sticky",   32'(err_sticky), 1);
      step(1'b0, 1'b0, "miss");
      check("miss.late_once", 32'(err_late), 0);
      step(1'b0, 1'b0, "miss");
      step(1'b1, 1'b0, "resume");
      for (int i = 0; i < 3; i++) pulse_after(4, "resume");
      check("resume.not_yet", 32'(locked), 0);
      pulse_after(4, "resume");
      check("resume.locked", 32'(locked), 1);

      // Early pulse raced against clr
      step(1'b0, 1'b1, "clr");
      check("clr.sticky_cleared", 32'(err_sticky), 0);
      step(1'b0, 1'b0, "early");
      step(1'b1, 1'b1, "early");
      check("early.err_early", 32'(err_early), 1);
      check("early.period",    32'(period),    3);
      check("early.locked",    32'(locked),    0);
      check("race.sticky",     32'(err_sticky), 1);
      step(1'b0, 1'b1, "clr2");
      check("clr2.sticky", 32'(err_sticky), 0);

      // Timeout from ACQ back to IDLE
      pulse_after(3, "acq");
      check("acq.period", 32'(period), 4);
      for (int i = 0; i < 260; i++) step(1'b0, 1'b0, "timeout");
      step(1'b1, 1'b0, "idle_pulse");
      check("idle_pulse.period_kept", 32'(period), 4);
      pulse_after(5, "acq2");
      check("acq2.period", 32'(period), 5);

      // Async reset mid-lock
      for (int i = 0; i < 4; i++) pulse_after(4, "relock");
      check("relock.locked", 32'(locked), 1);
      #3 rst = 1'b1;
      #1;
      check("areset.locked",     32'(locked),     0);
      check("areset.period",     32'(period),     0);
      check("areset.err_early",  32'(err_early),  0);
      check("areset.err_late",   32'(err_late),   0);
      check("areset.err_sticky", 32'(err_sticky), 0);
      model_reset();
      #1 rst = 1'b0;

      // Random pulse spacing with sporadic clr
      for (int n = 0; n < 150; n++) begin
         int r, g;
         r = int'($urandom_range(0, 15));
         if (r < 10)      g = 4;
         else if (r < 12) g = 3;
         else if (r < 13) g = 5;
         else if (r < 14) g = 2;
         else if (r < 15) g = 1;
         else             g = 300;
         for (int i = 0; i < g; i++) begin
            step((i == g - 1), ($urandom_range(0, 15) == 0), "random");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtframe_cen_monitor.md
Name: jtframe_cen_monitor

Overview:
Receiving end of the clock-enable generators. Watches one clock-enable pulse train on the same clock, measures the spacing between pulses and checks it against an expected period. Reports lock status, the last measured period and early/late errors. Used in sims and on-target debug to prove that the CPU, sound and video enables run at the intended rates.

Parameters:
PW, 8, width of the period counter and the period output
EXP, 4, expected clk cycles between enables (4 = 6 MHz enable from a 24 MHz clock)
TOL, 0, allowed deviation in cycles; a period is good when EXP-TOL <= period <= EXP+TOL
LOCK_N, 4, consecutive good periods required to assert locked

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
cen  in  1  monitored clock-enable; one-cycle pulses
clr  in  1  clears err_sticky
locked  out  1  high while the pulse train is within tolerance
period  out  PW  last measured period in clk cycles
err_early  out  1  one-cycle pulse: period < EXP-TOL
err_late  out  1  one-cycle pulse: missing enable while LOCKED
err_sticky  out  1  set by any error, held until clr

Behaviour:
- Reset (async): state IDLE, cnt=0, good=0. Outputs reset to: locked=0, period=0, err_early=0, err_late=0, err_sticky=0.
- cnt counts clk cycles since the last cen:
  - loads 1 on the cycle after a cen;
  - otherwise increments;
  - saturates at 2^PW-1.
  - On a cen cycle, measured period = cnt (e.g. cen every 4 clocks gives 4).
- All outputs are registered and update on the edge after the triggering cen or condition (1-cycle latency).
- State IDLE: the first cen moves to ACQ. period is not updated.
- State ACQ: on each cen, period <= cnt.
  - Good period: good++; when good reaches LOCK_N, go to LOCKED and set locked=1.
  - Bad period: good=0, stay in ACQ. err_early is pulsed if short; no late error is raised in ACQ.
- State LOCKED: on each cen, period <= cnt.
  - Good period: stay in LOCKED.
  - Short period: pulse err_early, go to ERR, clear locked.
  - No cen and cnt==EXP+TOL: pulse err_late, go to ERR, clear locked.
- State ERR: the next cen updates period, sets good=0 and goes to ACQ.
- Timeout: in ACQ or ERR, cnt reaching 2^PW-1 returns the block to IDLE. period keeps its last value.
- Simultaneous events:
  - cen on the cycle where cnt==EXP+TOL: the cen wins and the period is evaluated; no late error.
  - clr and a new error in the same cycle: the error wins and err_sticky stays 1.
- The parameter check EXP+TOL < 2^PW-1 is enforced at elaboration; the block fails elaboration otherwise.

Optional Feature:
JTFRAME_CENMON_MINMAX_EN
- Defined: adds outputs pmin and pmax (PW bits each), the smallest and largest period measured since the last clr or reset.
  - Reset values: pmin=all ones, pmax=0.
  - Updated on every cen in ACQ, LOCKED and ERR.
  - clr reloads the reset values.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package jtframe_cenmon_pkg holds:
  - the state encoding (IDLE, ACQ, LOCKED, ERR);
  - the default PW, EXP, TOL and LOCK_N constants.
- One natural sub-module, jtframe_cenmon_cnt: the saturating period counter, producing cnt and the at-limit/at-max flags.

Test Plan:
All scenarios use EXP=4, TOL=0, LOCK_N=4.
- Lock: cen every 4 clocks from reset release -> locked rises the cycle after the 5th cen; period=4; no errors.
- Missing pulse: after lock, omit one cen -> err_late pulses once, 4 cycles after the last cen; locked falls; err_sticky=1. Resuming cen every 4 -> locked returns after 4 more good periods (5th cen after resuming).
- Early pulse: after lock, one cen 3 clocks after the previous one -> err_early pulse; period=3; locked=0.
- Sticky race: clr asserted on the same cycle an error is flagged -> err_sticky remains 1. A later clr alone -> 0.
- Timeout: stop cen while in ACQ -> after 255 cycles the block returns to IDLE. The next cen does not update period; the following one does.
- Async reset mid-lock: pulse rst between edges -> all outputs are 0 immediately, without waiting for a clock edge.
